// File: rtl/pit_pkg.sv
// Shared encodings and constants for the programmable interval timer control unit.
package pit_pkg;

    localparam int CNT_W   = 16;
    localparam int NUM_CNT = 3;

    // Read/write format field of the control word
    localparam logic [1:0] RW_LATCH = 2'b00;
    localparam logic [1:0] RW_LSB   = 2'b01;
    localparam logic [1:0] RW_MSB   = 2'b10;
    localparam logic [1:0] RW_WORD  = 2'b11;

    // Counter operating modes
    localparam logic [2:0] MODE0 = 3'd0;
    localparam logic [2:0] MODE1 = 3'd1;
    localparam logic [2:0] MODE2 = 3'd2;
    localparam logic [2:0] MODE3 = 3'd3;
    localparam logic [2:0] MODE4 = 3'd4;
    localparam logic [2:0] MODE5 = 3'd5;

    // Control word field positions
    localparam int CW_SC_HI = 7;
    localparam int CW_SC_LO = 6;
    localparam int CW_RW_HI = 5;
    localparam int CW_RW_LO = 4;
    localparam int CW_M_HI  = 3;
    localparam int CW_M_LO  = 1;
    localparam int CW_BCD   = 0;

    localparam logic [1:0] SC_READBACK = 2'b11;
    localparam logic [1:0] ADDR_CTRL   = 2'b11;

    // Modes 6 and 7 are aliases of the two periodic modes.
    function automatic logic [2:0] map_mode(input logic [2:0] m);
        logic [2:0] r;
        case (m)
            3'd6:    r = MODE2;
            3'd7:    r = MODE3;
            default: r = m;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pit_counter_if.sv
// Per-counter bus interface: format/mode registers, byte toggles, count latch,
// load/config strobes and the byte presented for readback.
module pit_counter_if
    import pit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             ctrl_wr,
    input  logic             latch_cmd,
    input  logic [1:0]       rw_in,
    input  logic [2:0]       mode_in,
    input  logic             bcd_in,
    input  logic             data_wr,
    input  logic             data_rd,
    input  logic [7:0]       din,
    input  logic [CNT_W-1:0] cur_count,
    output logic [2:0]       mode,
    output logic             bcd,
    output logic             cfg_strobe,
    output logic [CNT_W-1:0] load_value,
    output logic             load_strobe,
    output logic [7:0]       rd_byte
);

    logic [1:0]       rw_fmt;
    logic             wtog;
    logic             rtog;
    logic [7:0]       staged;
    logic             latched;
    logic [CNT_W-1:0] latch_reg;
    logic [CNT_W-1:0] rd_src;

    // Byte the next read would return: latched snapshot if held, else live count
    always_comb begin
        rd_src  = latched ? latch_reg : cur_count;
        rd_byte = 8'h00;
        case (rw_fmt)
            RW_LSB:  rd_byte = rd_src[7:0];
            RW_MSB:  rd_byte = rd_src[15:8];
            RW_WORD: rd_byte = rtog ? rd_src[15:8] : rd_src[7:0];
            default: rd_byte = 8'h00;
        endcase
    end

    // Programming, byte sequencing and latch bookkeeping; strobes are one-cycle pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            rw_fmt      <= RW_LATCH;
            mode        <= MODE0;
            bcd         <= 1'b0;
            wtog        <= 1'b0;
            rtog        <= 1'b0;
            staged      <= 8'h00;
            latched     <= 1'b0;
            latch_reg   <= '0;
            load_value  <= '0;
            load_strobe <= 1'b0;
            cfg_strobe  <= 1'b0;
        end else begin
            cfg_strobe  <= ctrl_wr;
            load_strobe <= 1'b0;
            if (ctrl_wr) begin
                // Reprogramming aborts any half-done byte sequence.
                rw_fmt  <= rw_in;
                mode    <= map_mode(mode_in);
                bcd     <= bcd_in;
                wtog    <= 1'b0;
                rtog    <= 1'b0;
                latched <= 1'b0;
            end else if (latch_cmd) begin
                // A second latch before readback completes keeps the first snapshot.
                if (!latched) begin
                    latch_reg <= cur_count;
                    latched   <= 1'b1;
                end
            end else if (data_wr) begin
                case (rw_fmt)
                    RW_LSB: begin
                        load_value  <= {8'h00, din};
                        load_strobe <= 1'b1;
                    end
                    RW_MSB: begin
                        load_value  <= {din, 8'h00};
                        load_strobe <= 1'b1;
                    end
                    RW_WORD: begin
                        if (!wtog) begin
                            staged <= din;
                            wtog   <= 1'b1;
                        end else begin
                            load_value  <= {din, staged};
                            wtog        <= 1'b0;
                            load_strobe <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end else if (data_rd) begin
                case (rw_fmt)
                    RW_LSB, RW_MSB: latched <= 1'b0;
                    RW_WORD: begin
                        rtog <= ~rtog;
                        if (rtog) begin
                            latched <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/pit_control_unit.sv
// Bus-side control unit for the three-counter interval timer: address and
// control word decode, per-counter interface instances and registered readback.
module pit_control_unit
    import pit_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cs,
    input  logic                     wr,
    input  logic                     rd,
    input  logic [1:0]               a,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    input  logic [NUM_CNT*CNT_W-1:0] cur_count,
    output logic [NUM_CNT*3-1:0]     cnt_mode,
    output logic [NUM_CNT-1:0]       cnt_bcd,
    output logic [NUM_CNT-1:0]       cfg_strobe,
    output logic [NUM_CNT*CNT_W-1:0] load_value,
    output logic [NUM_CNT-1:0]       load_strobe
);

    logic       acc_wr;
    logic       acc_rd;
    logic       ctrl_acc;
    logic [1:0] cw_sc;
    logic [1:0] cw_rw;
    logic [2:0] cw_mode;
    logic       cw_bcd;
    logic [7:0] rd_byte [NUM_CNT];
    logic [7:0] rd_sel;

    // Bus qualification; a write in the same cycle as a read drops the read
    always_comb begin
        acc_wr   = cs & wr;
        acc_rd   = cs & rd & ~wr;
        ctrl_acc = acc_wr & (a == ADDR_CTRL);
        cw_sc    = din[CW_SC_HI:CW_SC_LO];
        cw_rw    = din[CW_RW_HI:CW_RW_LO];
        cw_mode  = din[CW_M_HI:CW_M_LO];
        cw_bcd   = din[CW_BCD];
    end

    for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
        logic sel_ctrl;
        logic sel_latch;
        logic sel_wr;
        logic sel_rd;

        assign sel_ctrl  = ctrl_acc & (cw_sc == 2'(i)) & (cw_sc != SC_READBACK) & (cw_rw != RW_LATCH);
        assign sel_latch = ctrl_acc & (cw_sc == 2'(i)) & (cw_sc != SC_READBACK) & (cw_rw == RW_LATCH);
        assign sel_wr    = acc_wr & (a == 2'(i));
        assign sel_rd    = acc_rd & (a == 2'(i));

        pit_counter_if u_cnt (
            .clk         (clk),
            .rst         (rst),
            .ctrl_wr     (sel_ctrl),
            .latch_cmd   (sel_latch),
            .rw_in       (cw_rw),
            .mode_in     (cw_mode),
            .bcd_in      (cw_bcd),
            .data_wr     (sel_wr),
            .data_rd     (sel_rd),
            .din         (din),
            .cur_count   (cur_count[i*CNT_W +: CNT_W]),
            .mode        (cnt_mode[i*3 +: 3]),
            .bcd         (cnt_bcd[i]),
            .cfg_strobe  (cfg_strobe[i]),
            .load_value  (load_value[i*CNT_W +: CNT_W]),
            .load_strobe (load_strobe[i]),
            .rd_byte     (rd_byte[i])
        );
    end

    // Readback mux; the control address reads as zero
    always_comb begin
        rd_sel = 8'h00;
        case (a)
            2'd0:    rd_sel = rd_byte[0];
            2'd1:    rd_sel = rd_byte[1];
            2'd2:    rd_sel = rd_byte[2];
            default: rd_sel = 8'h00;
        endcase
    end

    // Registered read data, held until the next accepted read
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= 8'h00;
        end else if (acc_rd) begin
            dout <= rd_sel;
        end
    end

endmodule

// File: doc/pit_control_unit.md
Name: pit_control_unit

Overview:
Bus-side control unit for the three-counter programmable interval timer. It decodes control words and sequences the LSB/MSB byte protocol. It drives per-counter mode/config and load strobes into the counter blocks (modes 0-5), and services counter-latch commands and count readback. It sits between the 8-bit host bus and the counter instances; counters never see raw bus traffic.

Parameters:
CNT_W, 16, counter width in bits (fixed at 16 for 8254 compatibility)
NUM_CNT, 3, number of counters served (fixed at 3; SC field is 2 bits)

Ports:
clk  input  1  single system clock, all logic on posedge
rst  input  1  synchronous, active-high reset
cs  input  1  chip select, active high; when low all rd/wr ignored
wr  input  1  write request, sampled on posedge clk while cs=1
rd  input  1  read request, sampled on posedge clk while cs=1
a  input  2  address: 0..2 counter data ports, 3 control word
din  input  8  write data
dout  output  8  read data, registered
cur_count  input  3*CNT_W  live count of counters 2..0, concatenated
cnt_mode  output  3*3  mode per counter (0..5)
cnt_bcd  output  3  BCD select per counter (stored and forwarded only)
cfg_strobe  output  3  one-cycle pulse: counter n reprogrammed, go idle
load_value  output  3*CNT_W  initial count per counter
load_strobe  output  3  one-cycle pulse: load_value[n] is new and valid

Behaviour:
- Reset: cnt_mode=0 and cnt_bcd=0 for all counters; rw_fmt=00 (unprogrammed); write and read byte toggles cleared; latch flags cleared; dout=8'h00; load_value=0; all strobes 0.
- Access qualifier is acc=cs&(wr|rd). If wr and rd are both high, the write wins and the read is dropped.
- Control word (wr, a=3): SC=din[7:6], RW=din[5:4], M=din[3:1], BCD=din[0].
  - SC=3 (read-back): ignored, no state change.
  - RW=00 (latch): if latch[SC]=0, copy cur_count[SC] into latch_reg[SC] and set latch[SC]. If already latched, the command is ignored; the first latched value holds until it is fully read.
  - Otherwise: store rw_fmt, mode and bcd. Mode 6 maps to 2 and mode 7 maps to 3. Clear both toggles and latch[SC]. Pulse cfg_strobe[SC] the next cycle.
- Data write (wr, a=n<3):
  - rw_fmt=00: ignored.
  - 01: load_value[n]={8'h00,din}, pulse load_strobe[n].
  - 10: load_value[n]={din,8'h00}, pulse load_strobe[n].
  - 11: first write stores LSB in staging and sets wtog. Second write sets load_value[n]={din,staged}, clears wtog and pulses load_strobe.
  - Strobes assert in the cycle after the accepted write; load_value is stable when the strobe is high and holds afterwards.
- Read (rd, a=n<3): dout updates in the cycle after the accepted read and holds until the next read.
  - Source is latch_reg[n] if latch[n]=1, else cur_count[n] sampled at the read edge.
  - rw_fmt 01: LSB. 10: MSB. 11: LSB first, then MSB, with rtog alternating.
  - latch[n] clears after the final byte of the format is read (01/10: that read; 11: the MSB read).
  - rw_fmt=00: dout=8'h00.
- Read of a=3: dout=8'h00.
- Reprogramming mid-sequence (control word between LSB and MSB) aborts the sequence: toggles cleared, staged byte discarded, no load_strobe.
- Per-counter state is independent; interleaved accesses to different counters never disturb each other's toggles.
- rst mid-sequence returns everything to reset values on the next edge; strobes in flight are cancelled.
- cs low: no state change at all, including toggles.

Decomposition:
- Shared package pit_pkg holds:
  - RW encodings (RW_LATCH=00, RW_LSB, RW_MSB, RW_WORD);
  - mode localparams MODE0..MODE5;
  - control-word field bit positions and the SC_READBACK constant;
  - NUM_CNT and CNT_W.
- Sub-module pit_counter_if, instantiated 3 times. Per counter it holds rw_fmt, mode, bcd, wtog, rtog, staging byte, latch flag and latch_reg, and generates load/cfg strobes and its read byte.
- The top level does address decode and the dout mux.

Test Plan:
- Reset, then control word 8'h32 (ctr0, RW=11, mode1); write 8'h34, then 8'h12 -> cfg_strobe[0] pulses once. Exactly one load_strobe[0], after the second write, with load_value[0]=16'h1234 and cnt_mode[0]=1.
- Control 8'h52 (ctr1, RW=01, mode1); write 8'hAB -> load_value[1]=16'h00AB and a strobe after the single write. Control 8'hA4 (ctr2, RW=10, mode2); write 8'h05 -> load_value[2]=16'h0500.
- Ctr0 RW=11 with cur_count[0]=16'h0F0E; latch cmd 8'h00; change cur_count to 16'h0001; second latch cmd; two reads -> dout 8'h0E then 8'h0F. A further read returns the live value.
- Ctr0 RW=11; write LSB 8'h11; control word 8'h32 again; write 8'h22, then 8'h33 -> no strobe after 8'h11. load_value[0]=16'h3322 after the 8'h33 write.
- Simultaneous wr and rd on a=0 -> the write is applied and dout is unchanged. cs=0 with wr pulses -> no strobes and no toggle change. Control word 8'hC2 (read-back) -> no state change. Mode field 7 -> cnt_mode=3.
- Assert rst between LSB and MSB writes -> after reset all outputs are zero. A subsequent data write is ignored until a new control word is written.
